// File: rtl/lsq_ret_sched_if.sv
// Push and retire handshake bundle for the per-thread retire scheduler.
// slave = scheduler side, master = LSQ align stage / retire unit side.
interface lsq_ret_sched_if #(
  parameter int II_W   = 6,
  parameter int MASK_W = 6
);
  logic              push_en;
  logic              push_thread;
  logic [II_W-1:0]   push_II;
  logic [MASK_W-1:0] push_mask;
  logic [1:0]        push_rdy;
  logic              bStall;
  logic              ret_taken;
  logic              ret_valid;
  logic              ret_thread;
  logic [II_W-1:0]   ret_II;
  logic [MASK_W-1:0] ret_mask;

  modport master (
    output push_en, push_thread,
    output push_II, push_mask,
    input  push_rdy,
    output bStall, ret_taken,
    input  ret_valid, ret_thread,
    input  ret_II, ret_mask
  );

  modport slave (
    input  push_en, push_thread,
    input  push_II, push_mask,
    output push_rdy,
    input  bStall, ret_taken,
    output ret_valid, ret_thread,
    output ret_II, ret_mask
  );
endinterface

// File: rtl/lsq_ret_sched.sv
// Per-thread retire-bundle FIFOs with II-matched selection to the retire unit.
// Optional LSQ_RET_STALL_CNT_EN adds a saturating back-pressure counter.
module lsq_ret_sched #(
  parameter int DEPTH  = 4,
  parameter int II_W   = 6,
  parameter int MASK_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  lsq_ret_sched_if.slave           bus,
  input  logic [II_W-1:0]          cntrl_II0,
  input  logic [II_W-1:0]          cntrl_II1,
  input  logic                     except,
  input  logic                     except_thread,
  output logic [$clog2(DEPTH):0]   occ0,
  output logic [$clog2(DEPTH):0]   occ1
`ifdef LSQ_RET_STALL_CNT_EN
  ,
  input  logic                     stall_cnt_clr,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [II_W-1:0]   ii_mem   [2][DEPTH];
  logic [MASK_W-1:0] mask_mem [2][DEPTH];
  logic [AW-1:0]     wr_ptr   [2];
  logic [AW-1:0]     rd_ptr   [2];
  logic [AW:0]       occ      [2];
  logic [II_W-1:0]   cntrl_II [2];

  logic [1:0] elig;
  logic [1:0] flush;
  logic [1:0] push_ok;
  logic [1:0] pop;
  logic       taken;
  logic       rr;
  logic       rr_nx;
  logic       sel;
  logic       load;

  logic              ret_valid_q;
  logic              ret_thread_q;
  logic [II_W-1:0]   ret_II_q;
  logic [MASK_W-1:0] ret_mask_q;

  assign cntrl_II[0] = cntrl_II0;
  assign cntrl_II[1] = cntrl_II1;
  assign taken       = bus.ret_taken && !bus.bStall;

  assign occ0 = occ[0];
  assign occ1 = occ[1];

  assign bus.push_rdy   = {occ[1] != FULL, occ[0] != FULL};
  assign bus.ret_valid  = ret_valid_q;
  assign bus.ret_thread = ret_thread_q;
  assign bus.ret_II     = ret_II_q;
  assign bus.ret_mask   = ret_mask_q;

  // A thread being flushed this cycle neither accepts, pops nor presents.
  always_comb begin
    elig    = '0;
    flush   = '0;
    push_ok = '0;
    pop     = '0;
    for (int t = 0; t < 2; t++) begin
      flush[t]   = except && (except_thread == 1'(t));
      elig[t]    = (occ[t] != '0)
                && (ii_mem[t][rd_ptr[t]] == cntrl_II[t])
                && !flush[t];
      push_ok[t] = bus.push_en
                && (bus.push_thread == 1'(t))
                && (occ[t] != FULL)
                && !flush[t];
      pop[t]     = (state == PRESENT) && taken
                && (ret_thread_q == 1'(t))
                && !flush[t];
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    load     = 1'b0;
    sel      = rr;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          load     = 1'b1;
          sel      = (&elig) ? rr : elig[1];
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (flush[ret_thread_q]) begin
          state_nx = FLUSH;
        end else if (taken) begin
          state_nx = IDLE;
          rr_nx    = ~ret_thread_q;
        end
      end
      FLUSH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr           <= 1'b0;
      ret_valid_q  <= 1'b0;
      ret_thread_q <= 1'b0;
      ret_II_q     <= '0;
      ret_mask_q   <= '0;
    end else begin
      state       <= state_nx;
      rr          <= rr_nx;
      ret_valid_q <= (state_nx == PRESENT);
      if (load) begin
        ret_thread_q <= sel;
        ret_II_q     <= ii_mem[sel][rd_ptr[sel]];
        ret_mask_q   <= mask_mem[sel][rd_ptr[sel]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < 2; t++) begin
        wr_ptr[t] <= '0;
        rd_ptr[t] <= '0;
        occ[t]    <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ii_mem[t][i]   <= '0;
          mask_mem[t][i] <= '0;
        end
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (flush[t]) begin
          wr_ptr[t] <= '0;
          rd_ptr[t] <= '0;
          occ[t]    <= '0;
        end else begin
          if (push_ok[t]) begin
            ii_mem[t][wr_ptr[t]]   <= bus.push_II;
            mask_mem[t][wr_ptr[t]] <= bus.push_mask;
            wr_ptr[t]              <= wr_ptr[t] + 1'b1;
          end
          if (pop[t]) begin
            rd_ptr[t] <= rd_ptr[t] + 1'b1;
          end
          unique case ({push_ok[t], pop[t]})
            2'b10:   occ[t] <= occ[t] + 1'b1;
            2'b01:   occ[t] <= occ[t] - 1'b1;
            default: occ[t] <= occ[t];
          endcase
        end
      end
    end
  end

`ifdef LSQ_RET_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (ret_valid_q && !taken && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsq_ret_sched.sv
// Directed bench for lsq_ret_sched: stimulus queues expected bundles,
// a negedge monitor checks each newly presented bundle.
module tb_lsq_ret_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] cntrl_II0 = 6'h3F;
  logic [5:0] cntrl_II1 = 6'h3F;
  logic       except = 1'b0;
  logic       except_thread = 1'b0;
  logic [2:0] occ0;
  logic [2:0] occ1;
`ifdef LSQ_RET_STALL_CNT_EN
  logic        stall_cnt_clr = 1'b0;
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       t;
    logic [5:0] ii;
    logic [5:0] m;
  } exp_t;

  exp_t expq[$];
  logic prev_v = 1'b0;

  lsq_ret_sched_if #(.II_W(6), .MASK_W(6)) bus ();

  lsq_ret_sched #(.DEPTH(4), .II_W(6), .MASK_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cntrl_II0     (cntrl_II0),
    .cntrl_II1     (cntrl_II1),
    .except        (except),
    .except_thread (except_thread),
    .occ0          (occ0),
    .occ1          (occ1)
`ifdef LSQ_RET_STALL_CNT_EN
    ,
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t, input logic [5:0] ii,
                      input logic [5:0] m);
    bus.push_en     = 1'b1;
    bus.push_thread = t;
    bus.push_II     = ii;
    bus.push_mask   = m;
    tick();
    bus.push_en = 1'b0;
  endtask

  task automatic expect_b(input logic t, input logic [5:0] ii,
                          input logic [5:0] m);
    exp_t e;
    e.t  = t;
    e.ii = ii;
    e.m  = m;
    expq.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.ret_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, int'(bus.ret_valid), 1);
  endtask

  task automatic take();
    bus.ret_taken = 1'b1;
    tick();
    bus.ret_taken = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.ret_valid && !prev_v) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got II %0d thread %0d expected none",
                   bus.ret_II, bus.ret_thread);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("mon_thread", int'(bus.ret_thread), int'(e.t));
          chk("mon_II", int'(bus.ret_II), int'(e.ii));
          chk("mon_mask", int'(bus.ret_mask), int'(e.m));
        end
      end
      prev_v = bus.ret_valid;
    end
  end

  initial begin
    bus.push_en     = 1'b0;
    bus.push_thread = 1'b0;
    bus.push_II     = '0;
    bus.push_mask   = '0;
    bus.bStall      = 1'b0;
    bus.ret_taken   = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_push_rdy", int'(bus.push_rdy), 3);
    chk("rst_ret_valid", int'(bus.ret_valid), 0);
    chk("rst_ret_II", int'(bus.ret_II), 0);
    chk("rst_occ0", int'(occ0), 0);
    chk("rst_occ1", int'(occ1), 0);
    rst = 1'b1;
    tick();

    push(1'b0, 6'd5, 6'h21);
    push(1'b0, 6'd6, 6'h12);
    push(1'b0, 6'd7, 6'h0C);
    chk("fill_occ0", int'(occ0), 3);
    chk("fill_push_rdy", int'(bus.push_rdy), 3);
    chk("fill_no_valid", int'(bus.ret_valid), 0);

    // one-cycle latency from eligibility
    expect_b(1'b0, 6'd5, 6'h21);
    cntrl_II0 = 6'd5;
    chk("lat_before", int'(bus.ret_valid), 0);
    tick();
    chk("lat_valid", int'(bus.ret_valid), 1);
    take();
    chk("take_valid", int'(bus.ret_valid), 0);
    chk("take_occ0", int'(occ0), 2);

    // stall hold
    expect_b(1'b0, 6'd6, 6'h12);
    cntrl_II0 = 6'd6;
    wait_valid("stall_present");
    bus.bStall    = 1'b1;
    bus.ret_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", int'(bus.ret_valid), 1);
      chk("stall_II", int'(bus.ret_II), 6);
      chk("stall_mask", int'(bus.ret_mask), 6'h12);
      chk("stall_occ0", int'(occ0), 2);
    end
    bus.bStall = 1'b0;
    tick();
    bus.ret_taken = 1'b0;
    chk("unstall_occ0", int'(occ0), 1);
    chk("unstall_valid", int'(bus.ret_valid), 0);

    expect_b(1'b0, 6'd7, 6'h0C);
    cntrl_II0 = 6'd7;
    wait_valid("drain7");
    take();
    cntrl_II0 = 6'h3F;
    chk("drain_occ0", int'(occ0), 0);

    // last take from thread 1 leaves rr=0
    push(1'b1, 6'd3, 6'h01);
    expect_b(1'b1, 6'd3, 6'h01);
    cntrl_II1 = 6'd3;
    wait_valid("rr_setup");
    take();
    cntrl_II1 = 6'h3F;

    // arbitration with both eligible
    push(1'b0, 6'd9, 6'h2A);
    push(1'b1, 6'd9, 6'h15);
    expect_b(1'b0, 6'd9, 6'h2A);
    expect_b(1'b1, 6'd9, 6'h15);
    cntrl_II0 = 6'd9;
    cntrl_II1 = 6'd9;
    tick();
    chk("arb_first", int'(bus.ret_thread), 0);
    take();
    chk("arb_gap", int'(bus.ret_valid), 0);
    wait_valid("arb_second_valid");
    chk("arb_second", int'(bus.ret_thread), 1);
    take();
    cntrl_II0 = 6'h3F;
    cntrl_II1 = 6'h3F;

    // full and wrap on thread 1
    push(1'b1, 6'd20, 6'h31);
    push(1'b1, 6'd21, 6'h32);
    push(1'b1, 6'd22, 6'h33);
    push(1'b1, 6'd23, 6'h34);
    chk("full_occ1", int'(occ1), 4);
    chk("full_push_rdy", int'(bus.push_rdy), 1);
    push(1'b1, 6'd24, 6'h35);
    chk("drop_occ1", int'(occ1), 4);
    for (int i = 0; i < 2; i++) begin
      expect_b(1'b1, 6'(20 + i), 6'(6'h31 + i));
      cntrl_II1 = 6'(20 + i);
      wait_valid("wrap_pop");
      take();
    end
    push(1'b1, 6'd25, 6'h36);
    push(1'b1, 6'd26, 6'h37);
    chk("wrap_occ1", int'(occ1), 4);
    for (int i = 0; i < 2; i++) begin
      expect_b(1'b1, 6'(22 + i), 6'(6'h33 + i));
      cntrl_II1 = 6'(22 + i);
      wait_valid("wrap_order");
      take();
    end
    chk("wrap_occ1_after", int'(occ1), 2);

    // flush while thread 1 is presented, with same-cycle take
    push(1'b0, 6'd40, 6'h3E);
    expect_b(1'b1, 6'd25, 6'h36);
    cntrl_II1 = 6'd25;
    wait_valid("flush_present");
    except        = 1'b1;
    except_thread = 1'b1;
    bus.ret_taken = 1'b1;
    tick();
    except        = 1'b0;
    bus.ret_taken = 1'b0;
    cntrl_II1     = 6'h3F;
    chk("flush_valid", int'(bus.ret_valid), 0);
    chk("flush_occ1", int'(occ1), 0);
    chk("flush_occ0", int'(occ0), 1);
    chk("flush_push_rdy", int'(bus.push_rdy), 3);
    expect_b(1'b0, 6'd40, 6'h3E);
    cntrl_II0 = 6'd40;
    tick();
    chk("flush_gap", int'(bus.ret_valid), 0);
    tick();
    chk("post_flush_valid", int'(bus.ret_valid), 1);
    take();
    cntrl_II0 = 6'h3F;
    chk("post_flush_occ0", int'(occ0), 0);

    repeat (3) tick();
    chk("scoreboard_empty", expq.size(), 0);

    // asynchronous reset mid-operation
    push(1'b0, 6'd50, 6'h11);
    chk("pre_rst_occ0", int'(occ0), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_occ0", int'(occ0), 0);
    chk("async_rst_rdy", int'(bus.push_rdy), 3);
    tick();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
